// File: rtl/noc_demux_buffered.sv
// Class-based packet demux: routes whole packets from one flit stream to one of
// CHANNELS outputs, each behind its own FIFO so a stalled output does not block the others.

module noc_demux_buffered_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         do_push, do_pop;

   // Extra pointer MSB tells a full FIFO apart from an empty one.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

module noc_demux_buffered #(
   parameter int FLIT_WIDTH    = 32,
   parameter int CHANNELS      = 7,
   parameter int CLASS_LSB     = 24,
   parameter int CLASS_WIDTH   = 3,
   parameter logic [(2**CLASS_WIDTH)*CHANNELS-1:0] MAPPING = '0,
   parameter int BUFFER_DEPTH  = 4,
   parameter int DEFAULT_CH    = 0,
   parameter bit DROP_UNMAPPED = 1'b0,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [FLIT_WIDTH-1:0]                in_flit,
   input  logic                                 in_last,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
   output logic [CHANNELS-1:0]                  out_last,
   output logic [CHANNELS-1:0]                  out_valid,
   input  logic [CHANNELS-1:0]                  out_ready,
   output logic [COUNT_WIDTH-1:0]               drop_count,
   output logic                                 busy
);
   localparam int NCLS = 2**CLASS_WIDTH;
   localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

   state_t                 state, state_n;
   logic [CHW-1:0]         act_ch, act_ch_n;
   logic [CHANNELS-1:0]    map_tbl [NCLS];
   logic [CLASS_WIDTH-1:0] head_cls;
   logic [CHANNELS-1:0]    head_mask;
   logic [CHW-1:0]         head_tgt;
   logic                   head_drop;
   logic [CHANNELS-1:0]    fifo_push, fifo_full, fifo_empty;
   logic                   cnt_inc;

   for (genvar k = 0; k < NCLS; k++) begin : g_map
      assign map_tbl[k] = MAPPING[k*CHANNELS +: CHANNELS];
   end

   assign head_cls  = in_flit[CLASS_LSB +: CLASS_WIDTH];
   assign head_mask = map_tbl[head_cls];
   assign head_drop = (head_mask == '0) && DROP_UNMAPPED;

   // Lowest set bit wins; multicast masks collapse to a single destination.
   always_comb begin
      head_tgt = CHW'(DEFAULT_CH);
      for (int i = CHANNELS-1; i >= 0; i--)
         if (head_mask[i]) head_tgt = CHW'(i);
   end

   always_comb begin
      state_n   = state;
      act_ch_n  = act_ch;
      in_ready  = 1'b0;
      fifo_push = '0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (head_drop) begin
               in_ready = 1'b1;
               if (in_valid) begin
                  cnt_inc = 1'b1;
                  if (!in_last) state_n = DROP;
               end
            end else begin
               in_ready = ~fifo_full[head_tgt];
               if (in_valid && in_ready) begin
                  fifo_push[head_tgt] = 1'b1;
                  if (!in_last) begin
                     act_ch_n = head_tgt;
                     state_n  = FWD;
                  end
               end
            end
         end
         FWD: begin
            in_ready = ~fifo_full[act_ch];
            if (in_valid && in_ready) begin
               fifo_push[act_ch] = 1'b1;
               if (in_last) state_n = IDLE;
            end
         end
         DROP: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         act_ch     <= '0;
         drop_count <= '0;
      end else begin
         state  <= state_n;
         act_ch <= act_ch_n;
         if (cnt_inc && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      end
   end

   assign busy = (state != IDLE);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [FLIT_WIDTH:0] dout;

      noc_demux_buffered_fifo #(.W(FLIT_WIDTH+1), .DEPTH(BUFFER_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (fifo_push[g]),
         .din   ({in_last, in_flit}),
         .pop   (out_ready[g]),
         .dout  (dout),
         .full  (fifo_full[g]),
         .empty (fifo_empty[g])
      );

      assign out_last[g]  = dout[FLIT_WIDTH];
      assign out_flit[g]  = dout[FLIT_WIDTH-1:0];
      assign out_valid[g] = ~fifo_empty[g];
   end
endmodule

// File: tb/tb_noc_demux_buffered.sv
// Directed bench: dut_a routes/forwards (default channel 3), dut_b drops unmapped classes
// with a 2-bit saturating counter. A per-channel queue scoreboard checks every output cycle.

module tb_noc_demux_buffered;
   localparam logic [31:0] MAP = 32'h0000_0641;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [31:0]      a_flit, b_flit;
   logic             a_last, a_valid, a_ready, b_last, b_valid, b_ready;
   logic [3:0][31:0] oa_flit, ob_flit;
   logic [3:0]       oa_last, oa_valid, oa_ready, ob_last, ob_valid, ob_ready;
   logic [15:0]      a_cnt;
   logic [1:0]       b_cnt;
   logic             a_busy, b_busy;

   noc_demux_buffered #(.FLIT_WIDTH(32), .CHANNELS(4), .CLASS_LSB(24), .CLASS_WIDTH(3),
      .MAPPING(MAP), .BUFFER_DEPTH(4), .DEFAULT_CH(3), .DROP_UNMAPPED(1'b0),
      .COUNT_WIDTH(16)) dut_a (
      .clk(clk), .rst(rst), .in_flit(a_flit), .in_last(a_last), .in_valid(a_valid),
      .in_ready(a_ready), .out_flit(oa_flit), .out_last(oa_last), .out_valid(oa_valid),
      .out_ready(oa_ready), .drop_count(a_cnt), .busy(a_busy));

   noc_demux_buffered #(.FLIT_WIDTH(32), .CHANNELS(4), .CLASS_LSB(24), .CLASS_WIDTH(3),
      .MAPPING(MAP), .BUFFER_DEPTH(4), .DEFAULT_CH(0), .DROP_UNMAPPED(1'b1),
      .COUNT_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .in_flit(b_flit), .in_last(b_last), .in_valid(b_valid),
      .in_ready(b_ready), .out_flit(ob_flit), .out_last(ob_last), .out_valid(ob_valid),
      .out_ready(ob_ready), .drop_count(b_cnt), .busy(b_busy));

   int checks = 0;
   int failures = 0;
   logic [32:0] qa [4][$];
   logic [32:0] qb [4][$];
   int  a_tgt, b_tgt;
   logic a_acc, b_acc, sb_en;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int cls, input int pay);
      return {5'b0, 3'(cls), 24'(pay)};
   endfunction

   // One clock: score outputs at the negedge, record accepted flits, advance past posedge.
   task automatic cyc();
      logic [32:0] e;
      @(negedge clk);
      if (sb_en) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_valid%0d", i), oa_valid[i], qa[i].size() != 0);
            if (oa_valid[i] && oa_ready[i] && qa[i].size() != 0) begin
               e = qa[i].pop_front();
               chk($sformatf("a_data%0d", i), {oa_last[i], oa_flit[i]}, e);
            end
            chk($sformatf("b_valid%0d", i), ob_valid[i], qb[i].size() != 0);
            if (ob_valid[i] && ob_ready[i] && qb[i].size() != 0) begin
               e = qb[i].pop_front();
               chk($sformatf("b_data%0d", i), {ob_last[i], ob_flit[i]}, e);
            end
         end
      end
      a_acc = a_valid & a_ready;
      b_acc = b_valid & b_ready;
      if (a_acc && a_tgt >= 0) qa[a_tgt].push_back({a_last, a_flit});
      if (b_acc && b_tgt >= 0) qb[b_tgt].push_back({b_last, b_flit});
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [31:0] f, input logic l, input int tgt);
      int n = 0;
      a_flit = f; a_last = l; a_tgt = tgt; a_valid = 1'b1;
      do begin cyc(); n++; end while (!a_acc && n < 40);
      if (!a_acc) chk("a_accept_timeout", 0, 1);
      a_valid = 1'b0;
   endtask

   task automatic send_b(input logic [31:0] f, input logic l);
      b_flit = f; b_last = l; b_tgt = -1; b_valid = 1'b1;
      cyc();
      chk("b_drop_ready", b_acc, 1'b1);
      b_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      a_flit = '0; a_last = 0; a_valid = 0; b_flit = '0; b_last = 0; b_valid = 0;
      oa_ready = 4'hF; ob_ready = 4'hF; a_tgt = -1; b_tgt = -1; sb_en = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_valid", oa_valid, 4'h0);
      chk("rst_b_valid", ob_valid, 4'h0);
      chk("rst_busy", {a_busy, b_busy}, 2'b00);
      chk("rst_cnt", {a_cnt, b_cnt}, 18'h0);
      rst = 1'b1; sb_en = 1;

      // Routing: 3-flit cls1 packet -> channel 2
      send_a(mk(1, 'h11), 0, 2);
      chk("route_busy_head", a_busy, 1'b1);
      send_a(mk(0, 'h12), 0, 2);
      chk("route_busy_mid", a_busy, 1'b1);
      send_a(mk(5, 'h13), 1, 2);
      chk("route_busy_end", a_busy, 1'b0);
      idle(3);

      // Priority: cls2 maps to channels 1 and 2, lowest wins
      send_a(mk(2, 'h21), 1, 1);
      chk("prio_busy", a_busy, 1'b0);
      idle(2);

      // Default: unmapped cls6 -> channel 3
      send_a(mk(6, 'h31), 0, 3);
      send_a(mk(6, 'h32), 1, 3);
      idle(3);
      chk("default_cnt", a_cnt, 16'd0);

      // Backpressure: ch1 holds a packet, ch0 fills up
      oa_ready = 4'b1100;
      send_a(mk(2, 'h41), 1, 1);
      for (int k = 0; k < 4; k++) send_a(mk(0, 'h50 + k), 0, 0);
      a_flit = mk(0, 'h54); a_last = 0; a_tgt = 0; a_valid = 1'b1;
      cyc(); chk("bp_stall0", a_acc, 1'b0);
      cyc(); chk("bp_stall1", a_acc, 1'b0);
      oa_ready[1] = 1'b1;
      cyc(); chk("bp_stall2", a_acc, 1'b0);
      cyc(); chk("bp_ch1_drained", oa_valid[1], 1'b0);
      oa_ready[0] = 1'b1;
      cyc(); chk("bp_full_on_pop", a_acc, 1'b0);
      cyc(); chk("bp_ready_after_pop", a_acc, 1'b1);
      a_valid = 1'b0;
      send_a(mk(0, 'h55), 1, 0);
      idle(6);
      chk("bp_busy", a_busy, 1'b0);

      // Drop on dut_b: cls5 3-flit, cls7 single, then saturation
      send_b(mk(5, 'h61), 0);
      chk("drop_busy", b_busy, 1'b1);
      send_b(mk(0, 'h62), 0);
      send_b(mk(1, 'h63), 1);
      send_b(mk(7, 'h64), 1);
      idle(2);
      chk("drop_cnt2", b_cnt, 2'd2);
      chk("drop_busy_end", b_busy, 1'b0);
      send_b(mk(3, 'h65), 1);
      send_b(mk(4, 'h66), 1);
      send_b(mk(7, 'h67), 1);
      idle(1);
      chk("drop_cnt_sat", b_cnt, 2'd3);

      // Reset mid-packet with two flits buffered on channel 2
      oa_ready = 4'b1011;
      send_a(mk(1, 'h71), 0, 2);
      send_a(mk(1, 'h72), 0, 2);
      chk("pre_rst_busy", a_busy, 1'b1);
      sb_en = 0; rst = 1'b0;
      cyc();
      for (int i = 0; i < 4; i++) begin qa[i].delete(); qb[i].delete(); end
      rst = 1'b1; sb_en = 1;
      chk("post_rst_valid", oa_valid, 4'h0);
      chk("post_rst_busy", a_busy, 1'b0);
      chk("post_rst_cnt", b_cnt, 2'd0);
      oa_ready = 4'hF;
      send_a(mk(1, 'h81), 1, 2);
      chk("post_rst_head_busy", a_busy, 1'b0);
      idle(3);

      for (int i = 0; i < 4; i++) chk($sformatf("sb_empty%0d", i), qa[i].size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/noc_demux_buffered.md
Name: noc_demux_buffered

Overview:
- Parametrised successor to the single-stage class demux. Routes whole packets from one input flit stream to one of CHANNELS outputs.
- The route is chosen from a configurable class field in the head flit, using a configurable mapping table.
- Each output has its own FIFO, so a stalled output does not block packets already routed elsewhere.
- Unmapped classes go to a default channel or are dropped and counted. Sits between the NoC router local port and endpoint-side consumers.

Parameters:
- FLIT_WIDTH, 32, flit width in bits.
- CHANNELS, 7, number of outputs (≥2).
- CLASS_LSB, 24, lowest bit of the class field in the head flit.
- CLASS_WIDTH, 3, class field width; the table has 2**CLASS_WIDTH entries.
- MAPPING, all zeros, width (2**CLASS_WIDTH)*CHANNELS. Entry k is MAPPING[k*CHANNELS +: CHANNELS], a channel mask for class k.
- BUFFER_DEPTH, 4, per-output FIFO depth; power of two, ≥2.
- DEFAULT_CH, 0, channel used for unmapped classes when DROP_UNMAPPED=0.
- DROP_UNMAPPED, 0, 1 = discard packets whose class entry is zero.
- COUNT_WIDTH, 16, width of drop_count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- in_flit  in  FLIT_WIDTH  input flit.
- in_last  in  1  last flit of packet.
- in_valid  in  1  input flit valid.
- in_ready  out  1  input flit accepted when in_valid & in_ready.
- out_flit  out  [CHANNELS][FLIT_WIDTH]  FIFO head flit per channel.
- out_last  out  [CHANNELS]  FIFO head last bit per channel.
- out_valid  out  [CHANNELS]  FIFO non-empty per channel.
- out_ready  in  [CHANNELS]  consumer pop per channel.
- drop_count  out  COUNT_WIDTH  number of dropped packets, saturating.
- busy  out  1  high when mid-packet (state ≠ IDLE).

Behaviour:
- Clock and reset: one clock. rst=0 sampled at a clk edge resets the block:
  - state → IDLE; all FIFOs empty; out_valid=0; drop_count=0; busy=0.
  - Reset mid-packet discards buffered flits and the partial route. The next accepted flit is treated as a head flit.
- Head decode (combinational, only in IDLE):
  - cls = in_flit[CLASS_LSB +: CLASS_WIDTH]; mask = MAPPING entry cls.
  - mask≠0: target = index of the lowest set bit of mask. Single destination only; no multicast.
  - mask=0 and DROP_UNMAPPED=0: target = DEFAULT_CH.
  - mask=0 and DROP_UNMAPPED=1: packet is dropped.
- State machine (states IDLE, FWD, DROP; register act_ch holds the locked channel):
  - IDLE, routed target: in_ready = ~full[target]. On accept, push the flit into FIFO[target]. If in_last=0: act_ch←target, go to FWD. Else stay in IDLE (single-flit packet).
  - IDLE, dropped: in_ready=1. On accept, drop_count increments (saturates at all-ones). If in_last=0: go to DROP. Else stay in IDLE.
  - FWD: in_ready = ~full[act_ch]; accepted flits are pushed to FIFO[act_ch]; the class field is ignored. Accept with in_last=1 → IDLE.
  - DROP: in_ready=1; flits are discarded. Accept with in_last=1 → IDLE. drop_count does not increment again.
- FIFOs:
  - Registered outputs: a flit accepted at edge N is visible on out_valid/out_flit after edge N; minimum latency is 1 cycle.
  - Pop on out_valid[i] & out_ready[i].
  - in_ready depends only on the full flag, never on out_ready (no combinational ready path). A full FIFO refuses a push even in a cycle where it pops.
  - Push and pop in the same cycle on a non-full, non-empty FIFO keep the occupancy unchanged.
  - Pointers are log2(BUFFER_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and low bits equal; empty = pointers equal.
  - Non-target FIFOs keep draining independently while the input is stalled.
- in_valid=0: no state change. out_valid never depends on in_valid.

Test Plan:
- Config for all scenarios: CHANNELS=4, CLASS_WIDTH=3, BUFFER_DEPTH=4. MAPPING: cls0→4'b0001, cls1→4'b0100, cls2→4'b0110, others 0.
- Routing: 3-flit packet, cls1, all out_ready=1 → flits appear on channel 2 only, each 1 cycle after acceptance. out_last[2]=1 on the third flit. busy high between head and last.
- Priority: single-flit packet, cls2 → delivered on channel 1 only (lowest set bit); state stays IDLE.
- Backpressure: out_ready[0]=0; 6-flit cls0 packet → 4 flits accepted, then in_ready=0. A FIFO1 packet already queued still drains. Raise out_ready[0] → in_ready returns 1 the cycle after the first pop; all 6 flits are delivered in order.
- Drop: DROP_UNMAPPED=1; packets cls5 (3 flits) then cls7 (1 flit) → in_ready=1 throughout, no out_valid on any channel, drop_count=2. With COUNT_WIDTH=2, 5 drops → drop_count=3.
- Default: DROP_UNMAPPED=0, DEFAULT_CH=3; 2-flit cls6 packet → delivered on channel 3.
- Reset: rst=0 mid-packet with 2 flits buffered → after the edge all out_valid=0 and busy=0. The next flit (cls1, last=1) is routed to channel 2 as a head flit.
